// File: rtl/apb_regbank.sv
// APB slave register bank: NUM_REGS word-addressed registers with a programmable
// number of wait states, address/alignment error reporting and registered outputs.
module apb_regbank #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_REGS    = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [1:0]            dbg_state
);
    // Handshake: a transfer starts on a setup cycle (PSEL=1, PENABLE=0) seen in IDLE;
    // it completes in the single cycle where PREADY=1 (DONE), where PSLVERR and
    // PRDATA are valid. PSEL dropping before DONE abandons the transfer.
    localparam int IW = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("apb_regbank: WAIT_STATES must be in 0..15");
    end

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  setup_err;
    logic                  fin;
    logic [IW-1:0]         f_idx;
    logic                  f_write;
    logic [DATA_WIDTH-1:0] f_wdata;
    logic                  f_err;
    logic [DATA_WIDTH-1:0] rd_val;

    assign setup_err = (PADDR[1:0] != 2'b00) ||
                       (32'(PADDR[ADDR_WIDTH-1:2]) >= 32'(NUM_REGS));

    // fin marks the DONE-entry edge; with no wait states the setup inputs are used
    // directly because the latched copies are not yet visible on that edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        fin     = 1'b0;
        f_idx   = idx_q;
        f_write = write_q;
        f_wdata = wdata_q;
        f_err   = err_q;
        case (state_q)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    idx_d   = PADDR[ADDR_WIDTH-1:2];
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    err_d   = setup_err;
                    cnt_d   = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d = S_DONE;
                        fin     = 1'b1;
                        f_idx   = PADDR[ADDR_WIDTH-1:2];
                        f_write = PWRITE;
                        f_wdata = PWDATA;
                        f_err   = setup_err;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (PENABLE) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = S_DONE;
                        fin     = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (f_idx == IW'(i)) begin
                rd_val = regs_q[i];
                if (fin && f_write && !f_err) begin
                    regs_d[i] = f_wdata;
                end
            end
        end
        pready_d  = fin;
        pslverr_d = fin && f_err;
        prdata_d  = (fin && !f_write && !f_err) ? rd_val : '0;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            regs_q    <= regs_d;
        end
    end

    assign PRDATA    = prdata_q;
    assign PREADY    = pready_q;
    assign PSLVERR   = pslverr_q;
    assign dbg_state = state_q;

endmodule

// File: doc/apb_regbank.md
APB_REGBANK -- requirements
Module: apb_regbank

Interface
REQ-001 Parameter DATA_WIDTH, default 8: register and PWDATA/PRDATA width (1..32).
REQ-002 Parameter NUM_REGS, default 16: register count (2..64), not required to be a power of two.
REQ-003 Parameter ADDR_WIDTH, default 8: PADDR width; word-addressed, register index = PADDR[ADDR_WIDTH-1:2].
REQ-004 Parameter WAIT_STATES, default 0: PREADY-low cycles inserted per access phase (0..15).
REQ-005 PCLK  input  1  sole clock; all state updates on rising edge.
REQ-006 PRESET  input  1  reset, asynchronous assert, active-high.
REQ-007 PSEL  input  1  APB slave select.
REQ-008 PENABLE  input  1  APB access-phase strobe.
REQ-009 PWRITE  input  1  1 = write, 0 = read.
REQ-010 PADDR  input  ADDR_WIDTH  byte address.
REQ-011 PWDATA  input  DATA_WIDTH  write data.
REQ-012 PRDATA  output  DATA_WIDTH  read data, registered.
REQ-013 PREADY  output  1  transfer complete.
REQ-014 PSLVERR  output  1  transfer error, valid only with PREADY=1.

Function
REQ-015 FSM SHALL have states IDLE, WAIT, DONE; state register reset to IDLE.
REQ-016 IDLE: PSEL=1 & PENABLE=0 (setup) SHALL latch PADDR, PWRITE, PWDATA, load wait counter with WAIT_STATES, go to WAIT if WAIT_STATES>0 else DONE.
REQ-017 WAIT: counter decrements by 1 per cycle while PSEL&PENABLE; at counter==1 next state DONE; PREADY=0 throughout WAIT.
REQ-018 DONE: PREADY=1 for exactly one cycle, then IDLE; total access phase = WAIT_STATES+1 cycles.
REQ-019 PREADY SHALL be 0 in IDLE and WAIT; PREADY is a registered state decode, no combinational path from inputs.
REQ-020 Error condition: latched index >= NUM_REGS or PADDR[1:0] != 0; evaluated at setup.
REQ-021 PSLVERR SHALL equal the error condition in DONE and 0 in every other state.
REQ-022 Write SHALL commit latched PWDATA to the indexed register on the DONE-entry edge only when PWRITE=1 and no error; errored writes leave all registers unchanged.
REQ-023 Read: PRDATA SHALL be loaded with the indexed register on the DONE-entry edge; loaded with 0 on error reads; held at 0 in all states except DONE.
REQ-024 A write followed immediately by a read of the same index SHALL return the new value.
REQ-025 PSEL dropping during WAIT (aborted transfer) SHALL return FSM to IDLE with no register update and no PREADY pulse.
REQ-026 PENABLE=1 while in IDLE (no setup seen) SHALL be ignored; no transfer started.
REQ-027 Back-to-back transfers: a setup in the cycle after DONE SHALL be accepted with no idle gap.
REQ-028 Wait counter SHALL be 4 bits; WAIT_STATES outside 0..15 is a parameter error.

Reset
REQ-029 PRESET=1 SHALL asynchronously force: state IDLE, counter 0, PRDATA 0, PREADY 0, PSLVERR 0, all registers 0.
REQ-030 Reset asserted mid-transfer SHALL abort it; no register write completes; first transfer after deassert starts from IDLE.
REQ-031 Reset deassertion is synchronised externally; first setup accepted on the first edge after deassert.

Verification
REQ-032 WAIT_STATES=0: write 0xA5 to PADDR 0x08, then read 0x08 -> PREADY high on first access cycle, PRDATA=0xA5, PSLVERR=0.
REQ-033 WAIT_STATES=3: read PADDR 0x00 after reset -> PREADY low 3 cycles, high on 4th, PRDATA=0x00.
REQ-034 NUM_REGS=12: write 0x3C to PADDR 0x30 (index 12) -> PSLVERR=1 with PREADY; read back of 0x2C and all others unchanged; read 0x30 -> PRDATA=0, PSLVERR=1.
REQ-035 Write to PADDR 0x05 (misaligned) -> PSLVERR=1, index 1 unchanged.
REQ-036 WAIT_STATES=4: deassert PSEL after 2 wait cycles of a write 0xFF to 0x04 -> no PREADY pulse, read of 0x04 returns prior value.
REQ-037 Write 0x77 to 0x0C, assert PRESET during its WAIT -> all outputs 0 immediately; read 0x0C after reset returns 0x00.
